// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch: digit type, digit limits,
// the mm:ss count record and the active-low seven-segment glyph table.
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t DIGIT_MAX    = 4'd9;

    typedef struct packed {
        bcd_t min_tens;
        bcd_t min_ones;
        bcd_t sec_tens;
        bcd_t sec_ones;
    } time_t;

    // Index n holds the active-low glyph for hex digit n (bit order g..a).
    localparam logic [15:0][6:0] SEG_AL = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic bcd_t clamp_digit(input logic [3:0] d, input bcd_t lim);
        return (d > lim) ? lim : d;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// One hex/BCD digit to seven segments; SEG_ACTIVE_LOW=0 inverts the glyph.
module seg7_decoder
    import stopwatch_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_ACTIVE_LOW ? SEG_AL[i_digit] : ~SEG_AL[i_digit];

endmodule

// File: rtl/bcd_stopwatch.sv
// BCD mm:ss up/down timer with 1 Hz prescaler, preset load, saturate/expire.
// Define BCD_STOPWATCH_LAP_EN to add the lap (display freeze) feature.
module bcd_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int MAX_MIN        = 99,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       CLOCK_50,
    input  logic       clear,
    input  logic       run,
    input  logic       dir,
    input  logic       load,
    input  logic [7:0] preset_min,
    input  logic [7:0] preset_sec,
    input  logic       lap,
    output logic       tick,
    output logic       done,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3
);

    localparam int             PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]  PRESC_RLD = PW'(CLK_HZ - 1);
    localparam time_t          T_MAX     = '{bcd_t'(MAX_MIN / 10), bcd_t'(MAX_MIN % 10),
                                             SEC_TENS_MAX, DIGIT_MAX};

    logic [PW-1:0] r_presc;
    time_t         r_cnt;
    logic          r_done;
    logic          r_chk;

    time_t         w_next;
    time_t         w_preset;
    time_t         w_disp;
    logic          w_tick;
    logic          w_term;
    logic          w_next_term;
    logic [3:0]    w_mo;
    logic [7:0]    w_min_val;

    assign w_tick      = run & ~r_done & ~clear & (r_presc == '0);
    assign w_term      = dir ? (r_cnt == '0)  : (r_cnt == T_MAX);
    assign w_next_term = dir ? (w_next == '0) : (w_next == T_MAX);

    always_comb begin
        w_next = r_cnt;
        if (!dir) begin
            if (r_cnt.sec_ones != DIGIT_MAX) w_next.sec_ones = r_cnt.sec_ones + 4'd1;
            else begin
                w_next.sec_ones = '0;
                if (r_cnt.sec_tens != SEC_TENS_MAX) w_next.sec_tens = r_cnt.sec_tens + 4'd1;
                else begin
                    w_next.sec_tens = '0;
                    if (r_cnt.min_ones != DIGIT_MAX) w_next.min_ones = r_cnt.min_ones + 4'd1;
                    else begin
                        w_next.min_ones = '0;
                        w_next.min_tens = r_cnt.min_tens + 4'd1;
                    end
                end
            end
        end else begin
            if (r_cnt.sec_ones != '0) w_next.sec_ones = r_cnt.sec_ones - 4'd1;
            else begin
                w_next.sec_ones = DIGIT_MAX;
                if (r_cnt.sec_tens != '0) w_next.sec_tens = r_cnt.sec_tens - 4'd1;
                else begin
                    w_next.sec_tens = SEC_TENS_MAX;
                    if (r_cnt.min_ones != '0) w_next.min_ones = r_cnt.min_ones - 4'd1;
                    else begin
                        w_next.min_ones = DIGIT_MAX;
                        w_next.min_tens = r_cnt.min_tens - 4'd1;
                    end
                end
            end
        end
    end

    // Minute clamp works on the value, so an illegal tens digit (A..F) also clamps.
    assign w_mo      = clamp_digit(preset_min[3:0], DIGIT_MAX);
    assign w_min_val = {4'b0, preset_min[7:4]} * 8'd10 + {4'b0, w_mo};

    always_comb begin
        w_preset.sec_ones = clamp_digit(preset_sec[3:0], DIGIT_MAX);
        w_preset.sec_tens = clamp_digit(preset_sec[7:4], SEC_TENS_MAX);
        w_preset.min_ones = w_mo;
        w_preset.min_tens = preset_min[7:4];
        if (w_min_val > 8'(MAX_MIN)) begin
            w_preset.min_tens = T_MAX.min_tens;
            w_preset.min_ones = T_MAX.min_ones;
        end
    end

    // r_chk marks the cycle after a load so a terminal preset raises done.
    always_ff @(posedge CLOCK_50) begin
        if (clear) begin
            r_presc <= PRESC_RLD;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_chk   <= 1'b0;
        end else if (load) begin
            r_presc <= PRESC_RLD;
            r_cnt   <= w_preset;
            r_done  <= 1'b0;
            r_chk   <= 1'b1;
        end else begin
            r_chk <= 1'b0;
            if (run && !r_done)
                r_presc <= (r_presc == '0) ? PRESC_RLD : r_presc - 1'b1;
            if (r_chk && w_term)
                r_done <= 1'b1;
            if (w_tick) begin
                if (w_term) r_done <= 1'b1;
                else begin
                    r_cnt <= w_next;
                    if (w_next_term) r_done <= 1'b1;
                end
            end
        end
    end

`ifdef BCD_STOPWATCH_LAP_EN
    logic  r_freeze;
    time_t r_snap;

    always_ff @(posedge CLOCK_50) begin
        if (clear) begin
            r_freeze <= 1'b0;
            r_snap   <= '0;
        end else if (lap) begin
            r_freeze <= ~r_freeze;
            if (!r_freeze) r_snap <= r_cnt;
        end
    end

    assign w_disp = r_freeze ? r_snap : r_cnt;
`else
    logic w_unused_lap;
    assign w_unused_lap = lap;
    assign w_disp       = r_cnt;
`endif

    logic [3:0][3:0] w_digits;
    logic [3:0][6:0] w_hex;

    assign w_digits = {w_disp.min_tens, w_disp.min_ones, w_disp.sec_tens, w_disp.sec_ones};

    for (genvar g = 0; g < 4; g++) begin : g_seg
        seg7_decoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg (
            .i_digit (w_digits[g]),
            .o_seg   (w_hex[g])
        );
    end

    assign tick     = w_tick;
    assign done     = r_done;
    assign sec_ones = w_digits[0];
    assign sec_tens = w_digits[1];
    assign min_ones = w_digits[2];
    assign min_tens = w_digits[3];
    assign HEX0     = w_hex[0];
    assign HEX1     = w_hex[1];
    assign HEX2     = w_hex[2];
    assign HEX3     = w_hex[3];

endmodule

// File: doc/bcd_stopwatch.md
# bcd_stopwatch

Parametrised BCD minutes:seconds timer for the DE-series boards. It counts up or down, can be loaded with a preset, saturates or expires cleanly, and optionally freezes its display for lap readings. It drives four seven-segment displays directly from CLOCK_50. It replaces the fixed two-digit seconds counter in board-level top modules and can also be instantiated as a reusable timing source, via its `tick` output.

## Interface
- `CLK_HZ`, 50_000_000, input clock frequency; the prescaler divides by this to produce 1 Hz.
- `MAX_MIN`, 99, highest minute value, legal range 1..99.
- `SEG_ACTIVE_LOW`, 1, 1 means segment outputs are active-low (DE board polarity); 0 inverts them.

Ports:
- `CLOCK_50`  in  1  sole clock; all state changes on its rising edge.
- `clear`  in  1  synchronous, active-high reset.
- `run`  in  1  level; counting advances only while high.
- `dir`  in  1  0 = count up, 1 = count down.
- `load`  in  1  single-cycle pulse; loads the preset.
- `preset_min`  in  8  two BCD digits, {tens, ones}.
- `preset_sec`  in  8  two BCD digits, {tens, ones}.
- `lap`  in  1  single-cycle pulse; toggles display freeze (only with `LAP_EN`).
- `tick`  out  1  one-cycle pulse per counted second.
- `done`  out  1  high when saturated (up) or expired (down).
- `sec_ones`, `sec_tens`, `min_ones`, `min_tens`  out  4 each  displayed BCD digits.
- `HEX0`..`HEX3`  out  7 each  segments for sec_ones, sec_tens, min_ones, min_tens.

## Operation
- **Prescaler:** down-counter, width $clog2(CLK_HZ), reset value CLK_HZ-1.
  - Decrements only while `run`=1 and `done`=0.
  - Holds its value while paused, so the phase is preserved across pauses.
  - On reaching 0 it reloads CLK_HZ-1 and asserts `tick`.
- **Priority per cycle:** `clear` > `load` > tick.
- **Up count:**
  - Seconds step 00..59. At 59 they wrap to 00 and the minutes increment.
  - Minutes increment in BCD (ones 9 → 0 with tens +1).
  - On reaching MAX_MIN:59, `done` goes high and counting is inhibited.
- **Down count:**
  - Seconds step 59..00. At 00 they borrow from the minutes, giving 59.
  - On reaching 00:00, `done` goes high and counting is inhibited.
- **`done` behaviour:**
  - `done`=1 suppresses `tick` and freezes the count.
  - `done` is cleared only by `clear` or `load`.
  - Changing `dir` does not clear `done`.
- **`dir` changes:** a change takes effect at the next tick. There is no glitch on the digits.
- **Load:**
  - Captures the preset, clears `done`, and reloads the prescaler with CLK_HZ-1.
  - Clamping rules:
    - Any ones digit >9 becomes 9.
    - A seconds tens digit >5 becomes 5.
    - A minute value >MAX_MIN becomes MAX_MIN.
  - Loading 00:00 with `dir`=1 sets `done` on the next cycle.
- **Clear:**
  - All digits are set to 0; `done`=0, `tick`=0; the prescaler is set to CLK_HZ-1; freeze is set to 0.
  - HEX outputs show "0" (7'b1000000 when active-low).
  - This applies at any time, including mid-count.

## Timing
- `tick` is high for exactly one cycle, every CLK_HZ cycles of `run`=1.
- The digit registers update on the edge that ends the `tick` cycle, so new digits are visible one cycle after `tick`.
- `done` rises in the same cycle that the terminal digits become visible.
- `load` results are visible the cycle after the pulse.
- HEX outputs are combinational from the displayed digits, with no extra latency.

## Configuration
- **`BCD_STOPWATCH_LAP_EN` defined:**
  - Each `lap` pulse toggles a freeze flag.
  - On entering freeze, the displayed digits and HEX outputs capture the live count and hold it.
  - The internal count, `tick` and `done` continue unaffected.
  - On leaving freeze, the displays show the live count again from the next cycle.
  - `load` does not alter the freeze state.
- **Macro undefined:** `lap` is ignored, there is no freeze register, and the displays always show the live count.

## Structure
- **Package `stopwatch_pkg`:**
  - BCD digit typedef (4-bit).
  - Constants SEC_TENS_MAX=5 and DIGIT_MAX=9.
  - Active-low segment patterns for 0–F.
- **Sub-module `seg7_decoder`:** one BCD/hex digit in, 7 segments out, with the polarity parameter; four instances.

## Test plan
All scenarios use CLK_HZ=4 for simulation.
- **Up count:** `clear` pulse, then `run`=1, `dir`=0 for 240 cycles -> 60 ticks; digits 01:00; HEX0=7'b1000000; `done`=0.
- **Up saturation:** MAX_MIN=2, load 02:58, run up -> 02:59 after 4 cycles; `done`=1; no further ticks.
- **Down expiry:** `dir`=1, load 00:02, run -> 00:01, then 00:00 with `done`=1; count held even after `dir` goes to 0.
- **Pause and clamp:** pause mid-prescale for 10 cycles -> next tick arrives after the remaining phase only. Load preset_sec=8'h7A -> clamped to 59.
- **Simultaneous events:** `clear` and `load` in the same cycle -> 00:00. `load` coincident with `tick` -> preset wins and no increment.
- **Lap (with `BCD_STOPWATCH_LAP_EN`):** `lap` at 00:03, run 8 cycles -> displays hold 00:03 while the internal count is 00:05; second `lap` -> displays show 00:05.
